// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the digit-serial subtractor.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    // Never returns 0, so a single-step (N = 1) build still has a legal counter width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sub_serial_sub4b.sv
// Combinational 4-bit borrow-lookahead slice: d = a - b - bin, with group borrow generate/propagate.
module sub4b
    import sub_serial_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              bin,
    output logic [NIBBLE-1:0] d,
    output logic              p,
    output logic              g,
    output logic              bout
);

    logic [NIBBLE-1:0] gi;
    logic [NIBBLE-1:0] pi;
    logic [NIBBLE:0]   bc;

    assign gi = ~a & b;
    assign pi = ~(a ^ b);

    // Every borrow is expanded directly from bin so no stage waits on a ripple.
    assign bc[0] = bin;
    assign bc[1] = gi[0] | (pi[0] & bin);
    assign bc[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & bin);
    assign bc[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                 | (pi[2] & pi[1] & pi[0] & bin);

    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p = &pi;
    assign bc[4] = g | (p & bin);

    assign d    = a ^ b ^ bc[NIBBLE-1:0];
    assign bout = bc[4];

endmodule

// File: rtl/sub_serial.sv
// Digit-serial WIDTH-bit subtractor (a - b - bin), one nibble per clock, start/busy/done handshake.
// Define SUB_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] aSh_q, aSh_d;
    logic [WIDTH-1:0] bSh_q, bSh_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
`ifdef SUB_SERIAL_OVF_EN
    logic             aMsb_q, aMsb_d;
    logic             bMsb_q, bMsb_d;
    logic             ovf_q, ovf_d;
`endif

    logic [NIBBLE-1:0] sliceD;
    logic              sliceP;
    logic              sliceG;
    logic              sliceBout;
    logic              unusedGroup;
    logic [WIDTH-1:0]  accShift;

    sub4b u_slice (
        .a    (aSh_q[NIBBLE-1:0]),
        .b    (bSh_q[NIBBLE-1:0]),
        .bin  (borrow_q),
        .d    (sliceD),
        .p    (sliceP),
        .g    (sliceG),
        .bout (sliceBout)
    );

    // The borrow chain is closed through the slice's own bout; group P/G are spare lookahead terms.
    assign unusedGroup = sliceP ^ sliceG;

    assign accShift = WIDTH'({sliceD, acc_q} >> NIBBLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        aSh_d    = aSh_q;
        bSh_d    = bSh_q;
        borrow_d = borrow_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
`ifdef SUB_SERIAL_OVF_EN
        aMsb_d   = aMsb_q;
        bMsb_d   = bMsb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    aSh_d    = a;
                    bSh_d    = b;
                    borrow_d = bin;
`ifdef SUB_SERIAL_OVF_EN
                    aMsb_d   = a[WIDTH-1];
                    bMsb_d   = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                aSh_d    = aSh_q >> NIBBLE;
                bSh_d    = bSh_q >> NIBBLE;
                borrow_d = sliceBout;
                acc_d    = accShift;
                cnt_d    = cnt_q + 1'b1;
                // Visible results update only here, so they hold steady through DONE and IDLE.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = accShift;
                    bout_d  = sliceBout;
                    zero_d  = (accShift == '0);
`ifdef SUB_SERIAL_OVF_EN
                    ovf_d   = (aMsb_q != bMsb_q) && (accShift[WIDTH-1] != aMsb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            aSh_q    <= '0;
            bSh_q    <= '0;
            borrow_q <= 1'b0;
            acc_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b1;
`ifdef SUB_SERIAL_OVF_EN
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            aSh_q    <= aSh_d;
            bSh_q    <= bSh_d;
            borrow_q <= borrow_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
`ifdef SUB_SERIAL_OVF_EN
            aMsb_q   <= aMsb_d;
            bMsb_q   <= bMsb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
`ifdef SUB_SERIAL_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial (WIDTH=16): arithmetic reference model, queued expectations, done-driven monitor.
module tb_sub_serial;

    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
        int           due;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    int   total;
    int   bad;
    int   cyc;
    int   busyCnt;
    exp_t expQ[$];
    exp_t lastExp;

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain wide arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        int   full;
        full   = int'(av) - int'(bv) - int'(bi);
        e.diff = W'(full);
        e.bout = (full < 0);
        e.zero = (e.diff == 0);
        e.ovf  = (av[W-1] != bv[W-1]) && (e.diff[W-1] != av[W-1]);
        e.due  = 0;
        return e;
    endfunction

    // Called at a falling edge; waits out any running operation, then issues one start.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        int   guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard = guard + 1;
        end
        if (guard >= 100) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL busy_timeout: busy stuck, got 1, want 0");
        end
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = bi;
        e     = model(av, bv, bi);
        e.due = cyc + 1 + N;
        expQ.push_back(e);
        lastExp = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseWhileBusy();
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            start = 1'b1;
            a     = 16'hFFFF;
            b     = W'($urandom);
            bin   = 1'b1;
            @(negedge clk);
            guard = guard + 1;
        end
        start = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busyCnt = 0;
        end else begin
            if (busy) busyCnt = busyCnt + 1;
            if (done) begin
                if (expQ.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("[TB] FAIL spurious_done: got done=1, want done=0 (cycle %0d)", cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("diff", diff, e.diff);
                    checkOutput("bout", W'(bout), W'(e.bout));
                    checkOutput("zero", W'(zero), W'(e.zero));
`ifdef SUB_SERIAL_OVF_EN
                    checkOutput("ovf", W'(ovf), W'(e.ovf));
`endif
                    checkOutput("done_cycle", W'(cyc), W'(e.due));
                    checkOutput("busy_cycles", W'(busyCnt), W'(N));
                end
                busyCnt = 0;
            end
        end
    end

    initial begin
        int guard;
        total   = 0;
        bad     = 0;
        cyc     = 0;
        busyCnt = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        bin     = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", W'(busy), '0);
        checkOutput("rst_done", W'(done), '0);
        checkOutput("rst_diff", diff, '0);
        checkOutput("rst_bout", W'(bout), '0);
        checkOutput("rst_zero", W'(zero), W'(1));
`ifdef SUB_SERIAL_OVF_EN
        checkOutput("rst_ovf", W'(ovf), '0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h0234, 1'b0);
        applyStimulus(16'h0000, 16'h0001, 1'b0);
        applyStimulus(16'hABCD, 16'hABCC, 1'b1);
        applyStimulus(16'h8000, 16'h0001, 1'b0);
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0);

        // Starts during busy must be ignored; a start in the DONE cycle chains directly.
        applyStimulus(16'h0005, 16'h0003, 1'b0);
        pulseWhileBusy();
        applyStimulus(16'h0010, 16'h0001, 1'b0);

        // Abort two cycles into RUN.
        while (busy) @(negedge clk);
        start = 1'b1;
        a     = 16'h4321;
        b     = 16'h1111;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", W'(busy), '0);
        checkOutput("abort_done", W'(done), '0);
        checkOutput("abort_diff", diff, '0);
        checkOutput("abort_zero", W'(zero), W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        applyStimulus(16'h9999, 16'h1234, 1'b1);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
        end

        guard = 0;
        while (expQ.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard = guard + 1;
        end
        if (expQ.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("[TB] FAIL drain: got %0d pending results, want 0", expQ.size());
        end

        repeat (3) @(negedge clk);
        checkOutput("hold_diff", diff, lastExp.diff);
        checkOutput("hold_zero", W'(zero), W'(lastExp.zero));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
# sub_serial

Digit-serial W-bit subtractor computing A − B − bin, 4 bits per clock, with a start/busy/done handshake. It is the subtract-direction counterpart of the 4-bit carry-lookahead adder path. It uses a 4-bit borrow-lookahead slice (generate/propagate on borrow) and a registered borrow chain, so wide operands cost area of one nibble. Typical use is in datapaths that need A − B, comparison flags, or signed-overflow detection without a full-width combinational subtractor.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibble steps
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy = 0
- a  in  WIDTH  minuend, captured on accepted start
- b  in  WIDTH  subtrahend, captured on accepted start
- bin  in  1  borrow-in, captured on accepted start
- busy  out  1  high while nibbles are being processed
- done  out  1  one-cycle pulse: results valid
- diff  out  WIDTH  a − b − bin mod 2^WIDTH, held until next accepted start
- bout  out  1  final borrow (1 ⇔ a < b + bin unsigned)
- zero  out  1  diff == 0
- ovf  out  1  signed overflow (only with SUB_SERIAL_OVF_EN)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1 captures the operands. a and b go into shift registers, bin into the borrow register, and the nibble counter is set to 0. The next state is RUN.
- RUN, each cycle:
  - The slice computes nibble k = a[3:0] − b[3:0] − borrow.
  - The result nibble shifts into diff from the MSB side.
  - The a and b registers shift right by 4 and borrow ← slice borrow-out.
  - The counter increments.
  - After the step with counter = N−1, the state goes to DONE.
- DONE lasts exactly one cycle, with done = 1. It then goes to IDLE unless start is accepted in that same cycle, in which case it goes to RUN.
- bout = last registered borrow. zero is registered together with the final nibble.
- Slice equations:
  - gi = ~ai & bi, pi = ~(ai ^ bi).
  - Borrow chain is lookahead: b_{i+1} = gi | pi & b_i.
  - di = ai ^ bi ^ b_i.
- start while busy = 1 is ignored, with no effect on the ongoing operation.
- diff, bout, zero and ovf change only on the final RUN step. They are stable in IDLE and DONE.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, counter = 0.
  - busy = 0, done = 0.
  - diff = 0, bout = 0, zero = 1, ovf = 0.
- Reset mid-operation aborts the operation with no done pulse. Outputs take their reset values.
- Latency: start accepted at edge T. busy = 1 for cycles T+1 … T+N. done = 1 in the cycle after edge T+N.
- Start-to-done is N+1 cycles (5 for WIDTH=16).
- Back-to-back throughput: one result per N+1 cycles, via start during DONE.
- WIDTH = 4: a single RUN cycle, so done appears 2 cycles after start.

## Configuration
- SUB_SERIAL_OVF_EN defined:
  - The ovf port exists.
  - ovf = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]), using the captured operand MSBs.
  - It is registered with the final nibble.
- SUB_SERIAL_OVF_EN undefined: the ovf port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package sub_serial_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the NIBBLE = 4 constant
  - the counter-width function clog2(N)
- One sub-module, sub4b: a combinational 4-bit borrow-lookahead slice.
  - Inputs: a[3:0], b[3:0], bin.
  - Outputs: d[3:0], group P, group G, bout.
  - Instantiated once.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234, bin=0 → done 5 cycles after start; diff=0x1000, bout=0, zero=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, zero=0; busy high exactly 4 cycles.
- a=0xABCD, b=0xABCC, bin=1 → diff=0x0000, bout=0, zero=1.
- OVF_EN build: a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1. Follow with a=0x7FFF, b=0xFFFF → diff=0x8000, ovf=1, bout=1.
- start with a=0x0005, b=0x0003; then start pulses with a=0xFFFF during busy → ignored, diff=0x0002. A start in the DONE cycle with a=0x0010, b=0x0001 → diff=0x000F, done 5 cycles later.
- Assert rst_n=0 two cycles into RUN → busy=0, no done pulse, diff=0, zero=1. A subsequent start completes normally.
